// File: rtl/bilinear_scale_ctrl_if.sv
// Bilinear scaler control bus: frame configuration and line-buffer fill level
// into the controller; line-buffer read addresses, coefficients and
// destination coordinates out of it.
//   master : controller side (bilinear_scale_ctrl)
//   slave  : line-buffer / calculation-stage side
interface bilinear_scale_ctrl_if #(
  parameter int unsigned AW = 12
);
  localparam int unsigned SW = 20;  // Q4.16 step width
  localparam int unsigned CW = 17;  // Q1.16 coefficient width

  logic [AW-1:0] cfg_src_w;
  logic [AW-1:0] cfg_src_h;
  logic [AW-1:0] cfg_dst_w;
  logic [AW-1:0] cfg_dst_h;
  logic [SW-1:0] cfg_step_x;
  logic [SW-1:0] cfg_step_y;
  logic [AW-1:0] src_rows_written;

  logic          rd_en;
  logic [AW-1:0] rd_col0;
  logic [AW-1:0] rd_col1;
  logic [AW-1:0] rd_row0;
  logic [AW-1:0] rd_row1;

  logic          coo_valid;
  logic [CW-1:0] coefficient1;
  logic [CW-1:0] coefficient2;
  logic [CW-1:0] coefficient3;
  logic [CW-1:0] coefficient4;
  logic [AW-1:0] dst_x;
  logic [AW-1:0] dst_y;
  logic          line_done;
  logic          frame_done;

  modport master (
    input  cfg_src_w, cfg_src_h, cfg_dst_w, cfg_dst_h,
    input  cfg_step_x, cfg_step_y, src_rows_written,
    output rd_en, rd_col0, rd_col1, rd_row0, rd_row1,
    output coo_valid, coefficient1, coefficient2, coefficient3, coefficient4,
    output dst_x, dst_y, line_done, frame_done
  );

  modport slave (
    output cfg_src_w, cfg_src_h, cfg_dst_w, cfg_dst_h,
    output cfg_step_x, cfg_step_y, src_rows_written,
    input  rd_en, rd_col0, rd_col1, rd_row0, rd_row1,
    input  coo_valid, coefficient1, coefficient2, coefficient3, coefficient4,
    input  dst_x, dst_y, line_done, frame_done
  );
endinterface

// File: rtl/bilinear_scale_ctrl.sv
// Bilinear scale-down sequencer for one frame. Steps a Q12.16 source position
// over every destination pixel, issues line-buffer read addresses, and one
// cycle later (aligned to the RAM read data) presents the Q1.16 weights and
// the destination coordinate. Each destination line waits until the source
// rows it needs have been written.
// Ports:
//   vin_clk      : clock
//   rst_n        : synchronous active-low reset
//   frame_sync_n : low = frame sync/abort (same effect as reset)
//   bus          : bilinear_scale_ctrl_if master (cfg in, read/coeff out)
module bilinear_scale_ctrl #(
  parameter int unsigned AW = 12,
  parameter int unsigned PW = 28
) (
  input  logic                      vin_clk,
  input  logic                      rst_n,
  input  logic                      frame_sync_n,
  bilinear_scale_ctrl_if.master     bus
);
  localparam int unsigned FW  = 16;
  localparam int unsigned SW  = 20;
  localparam int unsigned CW  = 17;
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned AW1 = AW + 1;
  localparam logic [CW-1:0] ONE = CW'(65536);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ROWS, RUN, LINE_END, DONE} state_t;

  state_t        state;
  logic [AW-1:0] src_w, src_h, dst_w, dst_h;
  logic [SW-1:0] step_x, step_y;
  logic [PW-1:0] pos_x, pos_y;
  logic [AW-1:0] x_cnt, y_cnt;
  logic          done_sent;

  // Read-stage payload carried to the coefficient stage
  logic [FW-1:0] s_fx, s_fy;
  logic [AW-1:0] s_dx, s_dy;
  logic          s_last;

  logic [AW-1:0] x_int, y_int, x0, x1, y0, y1;
  logic [FW-1:0] fx, fy;
  logic          rows_ok;

  // Saturating position step: pins at all-ones instead of wrapping
  function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a,
                                            input logic [SW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + PW1'(b);
    return s[PW] ? '1 : s[PW-1:0];
  endfunction

  // Integer/fraction split with right/bottom edge clamp
  always_comb begin
    x_int = AW'(pos_x >> FW);
    y_int = AW'(pos_y >> FW);
    x0    = x_int;
    x1    = x_int + AW'(1);
    fx    = pos_x[FW-1:0];
    y0    = y_int;
    y1    = y_int + AW'(1);
    fy    = pos_y[FW-1:0];
    if (x_int >= src_w - AW'(1)) begin
      x0 = src_w - AW'(1);
      x1 = src_w - AW'(1);
      fx = '0;
    end
    if (y_int >= src_h - AW'(1)) begin
      y0 = src_h - AW'(1);
      y1 = src_h - AW'(1);
      fy = '0;
    end
    rows_ok = ({1'b0, bus.src_rows_written} >= ({1'b0, y1} + AW1'(1)));
  end

  // FSM, read issue and one-cycle coefficient stage
  always_ff @(posedge vin_clk) begin
    if (!rst_n || !frame_sync_n) begin
      state             <= IDLE;
      src_w             <= '0;
      src_h             <= '0;
      dst_w             <= '0;
      dst_h             <= '0;
      step_x            <= '0;
      step_y            <= '0;
      pos_x             <= '0;
      pos_y             <= '0;
      x_cnt             <= '0;
      y_cnt             <= '0;
      done_sent         <= 1'b0;
      s_fx              <= '0;
      s_fy              <= '0;
      s_dx              <= '0;
      s_dy              <= '0;
      s_last            <= 1'b0;
      bus.rd_en         <= 1'b0;
      bus.rd_col0       <= '0;
      bus.rd_col1       <= '0;
      bus.rd_row0       <= '0;
      bus.rd_row1       <= '0;
      bus.coo_valid     <= 1'b0;
      bus.coefficient1  <= '0;
      bus.coefficient2  <= '0;
      bus.coefficient3  <= '0;
      bus.coefficient4  <= '0;
      bus.dst_x         <= '0;
      bus.dst_y         <= '0;
      bus.line_done     <= 1'b0;
      bus.frame_done    <= 1'b0;
    end else begin
      bus.rd_en      <= 1'b0;
      bus.frame_done <= 1'b0;

      // Coefficient stage lines up with the RAM read data
      bus.coo_valid <= bus.rd_en;
      bus.line_done <= bus.rd_en && s_last;
      if (bus.rd_en) begin
        bus.coefficient1 <= ONE - {1'b0, s_fx};
        bus.coefficient2 <= {1'b0, s_fx};
        bus.coefficient3 <= ONE - {1'b0, s_fy};
        bus.coefficient4 <= {1'b0, s_fy};
        bus.dst_x        <= s_dx;
        bus.dst_y        <= s_dy;
      end

      case (state)
        IDLE: begin
          src_w  <= bus.cfg_src_w;
          src_h  <= bus.cfg_src_h;
          dst_w  <= bus.cfg_dst_w;
          dst_h  <= bus.cfg_dst_h;
          step_x <= bus.cfg_step_x;
          step_y <= bus.cfg_step_y;
          state  <= LOAD;
        end
        LOAD: begin
          pos_x <= '0;
          pos_y <= '0;
          x_cnt <= '0;
          y_cnt <= '0;
          if (dst_w == '0 || dst_h == '0 || src_w == '0 || src_h == '0)
            state <= DONE;
          else
            state <= WAIT_ROWS;
        end
        WAIT_ROWS: begin
          if (rows_ok) state <= RUN;
        end
        RUN: begin
          bus.rd_en   <= 1'b1;
          bus.rd_col0 <= x0;
          bus.rd_col1 <= x1;
          bus.rd_row0 <= y0;
          bus.rd_row1 <= y1;
          s_fx        <= fx;
          s_fy        <= fy;
          s_dx        <= x_cnt;
          s_dy        <= y_cnt;
          s_last      <= (x_cnt == dst_w - AW'(1));
          pos_x       <= sat_add(pos_x, step_x);
          if (x_cnt == dst_w - AW'(1)) state <= LINE_END;
          else                         x_cnt <= x_cnt + AW'(1);
        end
        LINE_END: begin
          pos_x <= '0;
          x_cnt <= '0;
          if (y_cnt == dst_h - AW'(1)) begin
            state <= DONE;
          end else begin
            y_cnt <= y_cnt + AW'(1);
            pos_y <= sat_add(pos_y, step_y);
            state <= WAIT_ROWS;
          end
        end
        DONE: begin
          bus.frame_done <= !done_sent;
          done_sent      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
